// File: rtl/usr_ctrl.sv
// rtl/usr_ctrl.sv - command controller for an 8-bit universal shift register (optional ROTATE via USR_CTRL_ROTATE_EN)
module usr_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_cnt,
    input  logic [7:0] cmd_data,
    input  logic [7:0] usr_q,
    output logic [1:0] select,
    output logic [7:0] pload,
    output logic       lftin,
    output logic       rghtin,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] OP_LOAD    = 2'b00;
    localparam logic [1:0] OP_SHIFT_R = 2'b01;
    localparam logic [1:0] OP_SHIFT_L = 2'b10;
    localparam logic [1:0] OP_ROTATE  = 2'b11;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] op_r;
    logic [2:0] count;
    logic       fill_r;
    logic       dir_r;
    logic [7:0] pload_r;
    logic       accept;

    // Only the feedback taps of usr_q matter; this sinks the remaining bits.
    logic       unused_usr_q;
    assign unused_usr_q = ^usr_q;

    assign accept = cmd_valid && (state == S_IDLE);
    assign pload  = pload_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch, shift counter and parallel-load holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r    <= OP_LOAD;
            count   <= 3'd0;
            fill_r  <= 1'b0;
            dir_r   <= 1'b0;
            pload_r <= 8'h00;
        end else if (accept) begin
            op_r   <= cmd_op;
            count  <= cmd_cnt;
            fill_r <= cmd_data[0];
            dir_r  <= cmd_data[1];
            if (cmd_op == OP_LOAD) begin
                pload_r <= cmd_data;
            end
        end else if (state == S_SHIFT && count != 3'd0) begin
            count <= count - 3'd1;
        end
    end

    // Next-state decode and register-control outputs.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        select    = SEL_HOLD;
        lftin     = 1'b0;
        rghtin    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD:    state_nxt = S_LOAD;
                        OP_SHIFT_R: state_nxt = S_SHIFT;
                        OP_SHIFT_L: state_nxt = S_SHIFT;
`ifdef USR_CTRL_ROTATE_EN
                        OP_ROTATE:  state_nxt = S_SHIFT;
`else
                        OP_ROTATE:  state_nxt = S_DONE;
`endif
                        default:    state_nxt = S_IDLE;
                    endcase
                end
            end
            S_LOAD: begin
                select    = SEL_LOAD;
                state_nxt = S_DONE;
            end
            S_SHIFT: begin
                case (op_r)
                    OP_SHIFT_R: begin
                        select = SEL_RIGHT;
                        rghtin = fill_r;
                    end
                    OP_SHIFT_L: begin
                        select = SEL_LEFT;
                        lftin  = fill_r;
                    end
`ifdef USR_CTRL_ROTATE_EN
                    OP_ROTATE: begin
                        if (dir_r) begin
                            select = SEL_LEFT;
                            lftin  = usr_q[7];
                        end else begin
                            select = SEL_RIGHT;
                            rghtin = usr_q[0];
                        end
                    end
`endif
                    default: begin
                        select = SEL_HOLD;
                    end
                endcase
                if (count == 3'd0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // dir_r only steers ROTATE; keep it observed in builds without rotate.
    logic unused_dir;
    assign unused_dir = dir_r;

endmodule

// File: tb/tb_usr_ctrl.sv
// tb/tb_usr_ctrl.sv - self-checking bench for usr_ctrl with a behavioural universal shift register
module tb_usr_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_cnt = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] usr_q;
    logic [1:0] select;
    logic [7:0] pload;
    logic       lftin;
    logic       rghtin;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    usr_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .usr_q     (usr_q),
        .select    (select),
        .pload     (pload),
        .lftin     (lftin),
        .rghtin    (rghtin),
        .busy      (busy),
        .done      (done)
    );

    // Universal shift register driven by the controller.
    logic [7:0] q_reg = 8'h00;
    assign usr_q = q_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= 8'h00;
        end else begin
            case (select)
                2'b01:   q_reg <= {rghtin, q_reg[7:1]};
                2'b10:   q_reg <= {q_reg[6:0], lftin};
                2'b11:   q_reg <= pload;
                default: q_reg <= q_reg;
            endcase
        end
    end

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [2:0] cnt;
        logic [7:0] data;
        logic       rdy;
        logic       bsy;
        logic       dn;
        logic [1:0] sel;
        logic       lft;
        logic       rgt;
        logic [7:0] pl;
        logic [7:0] q;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [1:0] op, input logic [2:0] cnt, input logic [7:0] data,
                       input logic rdy, input logic bsy, input logic dn, input logic [1:0] sel,
                       input logic lft, input logic rgt, input logic [7:0] pl, input logic [7:0] q);
        vec_t e;
        e.v = v; e.op = op; e.cnt = cnt; e.data = data;
        e.rdy = rdy; e.bsy = bsy; e.dn = dn; e.sel = sel;
        e.lft = lft; e.rgt = rgt; e.pl = pl; e.q = q;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] cnt, input logic [7:0] data);
        cmd_valid = v;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
    endtask

    initial begin
        logic [7:0] shl_q[8];
        int lat;
        int pulses;
        logic got;

        // Reset state then LOAD A5
        add(1, 2'd0, 3'd0, 8'hA5, 1, 0, 0, 2'd0, 0, 0, 8'h00, 8'h00);
        add(0, 2'd0, 3'd0, 8'h00, 0, 1, 0, 2'd3, 0, 0, 8'hA5, 8'h00);
        add(0, 2'd0, 3'd0, 8'h00, 0, 1, 1, 2'd0, 0, 0, 8'hA5, 8'hA5);
        // LOAD F0, SHIFT_R cnt=3 fill=0, valid held high while busy
        add(1, 2'd0, 3'd0, 8'hF0, 1, 0, 0, 2'd0, 0, 0, 8'hA5, 8'hA5);
        add(0, 2'd0, 3'd0, 8'h00, 0, 1, 0, 2'd3, 0, 0, 8'hF0, 8'hA5);
        add(0, 2'd0, 3'd0, 8'h00, 0, 1, 1, 2'd0, 0, 0, 8'hF0, 8'hF0);
        add(1, 2'd1, 3'd3, 8'h00, 1, 0, 0, 2'd0, 0, 0, 8'hF0, 8'hF0);
        add(0, 2'd0, 3'd0, 8'h00, 0, 1, 0, 2'd1, 0, 0, 8'hF0, 8'hF0);
        add(1, 2'd0, 3'd0, 8'h55, 0, 1, 0, 2'd1, 0, 0, 8'hF0, 8'h78);
        add(1, 2'd2, 3'd7, 8'hFF, 0, 1, 0, 2'd1, 0, 0, 8'hF0, 8'h3C);
        add(1, 2'd0, 3'd0, 8'h55, 0, 1, 0, 2'd1, 0, 0, 8'hF0, 8'h1E);
        add(1, 2'd0, 3'd0, 8'h55, 0, 1, 1, 2'd0, 0, 0, 8'hF0, 8'h0F);
        // Back-to-back accept on first IDLE cycle: LOAD 00
        add(1, 2'd0, 3'd0, 8'h00, 1, 0, 0, 2'd0, 0, 0, 8'hF0, 8'h0F);
        add(0, 2'd0, 3'd0, 8'h00, 0, 1, 0, 2'd3, 0, 0, 8'h00, 8'h0F);
        add(0, 2'd0, 3'd0, 8'h00, 0, 1, 1, 2'd0, 0, 0, 8'h00, 8'h00);
        // SHIFT_L cnt=7 fill=1: eight shifts, busy nine cycles
        add(1, 2'd2, 3'd7, 8'h01, 1, 0, 0, 2'd0, 0, 0, 8'h00, 8'h00);
        shl_q = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};
        for (int i = 0; i < 8; i++) begin
            add(0, 2'd0, 3'd0, 8'h00, 0, 1, 0, 2'd2, 1, 0, 8'h00, shl_q[i]);
        end
        add(0, 2'd0, 3'd0, 8'h00, 0, 1, 1, 2'd0, 0, 0, 8'h00, 8'hFF);
        // SHIFT_R cnt=0 fill=1 (single shift), rotate-direction bit ignored
        add(1, 2'd1, 3'd0, 8'h03, 1, 0, 0, 2'd0, 0, 0, 8'h00, 8'hFF);
        add(0, 2'd0, 3'd0, 8'h00, 0, 1, 0, 2'd1, 0, 1, 8'h00, 8'hFF);
        add(0, 2'd0, 3'd0, 8'h00, 0, 1, 1, 2'd0, 0, 0, 8'h00, 8'hFF);
        add(0, 2'd0, 3'd0, 8'h00, 1, 0, 0, 2'd0, 0, 0, 8'h00, 8'hFF);

        // Reset sequence
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].cnt, tbl[i].data);
            #1;
            check($sformatf("vec%0d rdy/busy/done/sel/lft/rgt/pload/q", i),
                  {9'd0, cmd_ready, busy, done, select, lftin, rghtin, pload, usr_q},
                  {9'd0, tbl[i].rdy, tbl[i].bsy, tbl[i].dn, tbl[i].sel, tbl[i].lft, tbl[i].rgt, tbl[i].pl, tbl[i].q});
            @(negedge clk);
        end

        // LOAD 81 then ROTATE right cnt=1
        drive(1, 2'd0, 3'd0, 8'h81);
        @(negedge clk);
        drive(0, 2'd0, 3'd0, 8'h00);
        repeat (3) @(negedge clk);
        check("load81 q", {24'd0, usr_q}, 32'h81);
        drive(1, 2'd3, 3'd1, 8'h00);
        @(negedge clk);
        drive(0, 2'd0, 3'd0, 8'h00);
        lat = 1;
        got = 1'b0;
        while (lat < 12 && !got) begin
            #1;
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check("rotate done seen", {31'd0, got}, 32'd1);
`ifdef USR_CTRL_ROTATE_EN
        check("rotate done latency", lat, 32'd3);
        check("rotate q", {24'd0, usr_q}, 32'h60);
`else
        check("rotate-nop done latency", lat, 32'd1);
        check("rotate-nop q", {24'd0, usr_q}, 32'h81);
`endif
        @(negedge clk);
        #1;
        check("idle after rotate", {31'd0, cmd_ready}, 32'd1);

        // Reset in the 2nd cycle of SHIFT_R cnt=7
        @(negedge clk);
        drive(1, 2'd1, 3'd7, 8'h01);
        @(negedge clk);
        drive(0, 2'd0, 3'd0, 8'h00);
        #1;
        check("shift started", {30'd0, select}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after reset rdy/busy/done/sel/pload",
              {19'd0, cmd_ready, busy, done, select, pload}, {19'd0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00});
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            @(negedge clk);
            #1;
        end
        check("no done after abort", pulses, 32'd0);

        // Reset wins over a simultaneous accept
        @(negedge clk);
        rst = 1'b1;
        drive(1, 2'd0, 3'd0, 8'h3C);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 2'd0, 3'd0, 8'h00);
        #1;
        check("rst priority busy/sel/pload", {21'd0, busy, select, pload}, 32'd0);
        @(negedge clk);
        #1;
        check("rst priority still idle", {30'd0, cmd_ready, busy}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
